t09_digit_capture: RTL and testbench

T09_DIGIT_CAPTURE -- requirements
Module: t09_digit_capture

---
 rtl/t09_disp_pkg.sv | 37 +++
 rtl/t09_bcd_to_seg.sv | 26 ++
 rtl/t09_digit_capture.sv | 114 +++++++++++
 tb/tb_t09_digit_capture.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/t09_disp_pkg.sv
// Shared definitions for the multiplexed BCD digit capture block: FSM states,
// digit-slot indices, seven-segment patterns (gfedcba) and a BCD helper.
package t09_disp_pkg;

  typedef enum logic [1:0] {
    EXP0 = 2'd0,
    EXP1 = 2'd1,
    EXP2 = 2'd2
  } state_t;

  localparam logic [1:0] IDX_ONES     = 2'd0;
  localparam logic [1:0] IDX_TENS     = 2'd1;
  localparam logic [1:0] IDX_HUNDREDS = 2'd2;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

  function automatic logic [9:0] bcd3_to_bin(input logic [3:0] h,
                                             input logic [3:0] t,
                                             input logic [3:0] o);
    return 10'(h) * 10'd100 + 10'(t) * 10'd10 + 10'(o);
  endfunction

endpackage

// File: rtl/t09_bcd_to_seg.sv
// BCD digit to active-high seven-segment decoder (gfedcba); non-BCD values blank.
module t09_bcd_to_seg
  import t09_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/t09_digit_capture.sv
// Captures a ones/tens/hundreds BCD frame from a multiplexed digit bus and drives
// binary and seven-segment views of it. Optional leading-zero blanking: T09_LZ_BLANK_EN.
module t09_digit_capture
  import t09_disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic [1:0] sel_in,
  input  logic       err_clr,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic [9:0] value_bin,
  output logic [6:0] seg_ones,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_hundreds,
  output logic       frame_valid,
  output logic       seq_err
);

  state_t     state, next_state;
  logic [1:0] sel_d;
  logic       prime;
  logic [3:0] shadow_ones, shadow_tens;
  logic       load_ones, load_tens, commit, err_set;

  // Select register aligns sel with the digit that arrives a cycle later
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EXP0;
      sel_d <= 2'd0;
      prime <= 1'b0;
    end else begin
      state <= next_state;
      sel_d <= sel_in;
      prime <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    load_ones  = 1'b0;
    load_tens  = 1'b0;
    commit     = 1'b0;
    err_set    = 1'b0;
    if (prime) begin
      if (sel_d == 2'd3 || !is_bcd(digit_in)) begin
        err_set    = 1'b1;
        next_state = EXP0;
      end else if (sel_d == IDX_ONES) begin
        // A ones digit always restarts the frame; mid-frame it is a resync
        load_ones  = 1'b1;
        err_set    = (state != EXP0);
        next_state = EXP1;
      end else if (state == EXP1 && sel_d == IDX_TENS) begin
        load_tens  = 1'b1;
        next_state = EXP2;
      end else if (state == EXP2 && sel_d == IDX_HUNDREDS) begin
        commit     = 1'b1;
        next_state = EXP0;
      end else begin
        err_set    = 1'b1;
        next_state = EXP0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_ones <= 4'd0;
      shadow_tens <= 4'd0;
      ones        <= 4'd0;
      tens        <= 4'd0;
      hundreds    <= 4'd0;
      value_bin   <= 10'd0;
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      if (load_ones) shadow_ones <= digit_in;
      if (load_tens) shadow_tens <= digit_in;
      if (commit) begin
        ones      <= shadow_ones;
        tens      <= shadow_tens;
        hundreds  <= digit_in;
        value_bin <= bcd3_to_bin(digit_in, shadow_tens, shadow_ones);
      end
      frame_valid <= commit;
      // A new error outranks a simultaneous clear
      if (err_set)      seq_err <= 1'b1;
      else if (err_clr) seq_err <= 1'b0;
    end
  end

  logic [6:0] raw_ones, raw_tens, raw_hundreds;
  logic       blank_tens, blank_hundreds;

  t09_bcd_to_seg u_seg_ones     (.bcd(ones),     .seg(raw_ones));
  t09_bcd_to_seg u_seg_tens     (.bcd(tens),     .seg(raw_tens));
  t09_bcd_to_seg u_seg_hundreds (.bcd(hundreds), .seg(raw_hundreds));

`ifdef T09_LZ_BLANK_EN
  assign blank_hundreds = (hundreds == 4'd0);
  assign blank_tens     = blank_hundreds && (tens == 4'd0);
`else
  assign blank_hundreds = 1'b0;
  assign blank_tens     = 1'b0;
`endif

  assign seg_ones     = raw_ones;
  assign seg_tens     = blank_tens     ? SEG_BLANK : raw_tens;
  assign seg_hundreds = blank_hundreds ? SEG_BLANK : raw_hundreds;

endmodule

// File: tb/tb_t09_digit_capture.sv
// Self-checking bench for t09_digit_capture: directed vector table plus randomized
// traffic against a frame-level reference model.
module tb_t09_digit_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic [1:0] sel_in = 2'd0;
  logic       err_clr = 1'b0;
  logic [3:0] ones, tens, hundreds;
  logic [9:0] value_bin;
  logic [6:0] seg_ones, seg_tens, seg_hundreds;
  logic       frame_valid, seq_err;

  always #5 clk = ~clk;

  t09_digit_capture dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .sel_in(sel_in), .err_clr(err_clr),
    .ones(ones), .tens(tens), .hundreds(hundreds), .value_bin(value_bin),
    .seg_ones(seg_ones), .seg_tens(seg_tens), .seg_hundreds(seg_hundreds),
    .frame_valid(frame_valid), .seq_err(seq_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a list of accepted digits for the frame in progress
  int m_prev_sel, m_prime, m_cnt;
  int m_frame [3];
  int m_ones, m_tens, m_hund, m_val, m_fv, m_err;
  int prev_fv;

  function automatic logic [6:0] seg_ref(input int d);
    logic [6:0] lut [10];
    lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (d < 0 || d > 9) return 7'h00;
    return lut[d];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev_sel = 0; m_prime = 0; m_cnt = 0;
    m_ones = 0; m_tens = 0; m_hund = 0; m_val = 0; m_fv = 0; m_err = 0;
  endtask

  task automatic model_edge(input int rstn, input int sel, input int dig, input int clr);
    int err_set;
    if (rstn == 0) begin
      model_reset();
      return;
    end
    err_set = 0;
    m_fv = 0;
    if (m_prime != 0) begin
      if (m_prev_sel == 3 || dig > 9) begin
        err_set = 1; m_cnt = 0;
      end else if (m_prev_sel == 0) begin
        if (m_cnt != 0) err_set = 1;
        m_frame[0] = dig; m_cnt = 1;
      end else if (m_prev_sel == m_cnt) begin
        m_frame[m_cnt] = dig; m_cnt++;
        if (m_cnt == 3) begin
          m_ones = m_frame[0]; m_tens = m_frame[1]; m_hund = m_frame[2];
          m_val = 100 * m_hund + 10 * m_tens + m_ones;
          m_fv = 1; m_cnt = 0;
        end
      end else begin
        err_set = 1; m_cnt = 0;
      end
    end
    if (err_set != 0) m_err = 1;
    else if (clr != 0) m_err = 0;
    m_prev_sel = sel;
    m_prime = 1;
  endtask

  task automatic check_model();
    int exp_sh, exp_st;
    exp_sh = seg_ref(m_hund);
    exp_st = seg_ref(m_tens);
`ifdef T09_LZ_BLANK_EN
    if (m_hund == 0) exp_sh = 0;
    if (m_hund == 0 && m_tens == 0) exp_st = 0;
`endif
    check("frame_valid", frame_valid, m_fv);
    check("seq_err", seq_err, m_err);
    check("ones", ones, m_ones);
    check("tens", tens, m_tens);
    check("hundreds", hundreds, m_hund);
    check("value_bin", value_bin, m_val);
    check("seg_ones", seg_ones, seg_ref(m_ones));
    check("seg_tens", seg_tens, exp_st);
    check("seg_hundreds", seg_hundreds, exp_sh);
    if (prev_fv != 0) check("fv_no_back_to_back", frame_valid, 0);
    prev_fv = frame_valid;
  endtask

  task automatic step(input int rstn, input int sel, input int dig, input int clr);
    rst = rstn[0]; sel_in = sel[1:0]; digit_in = dig[3:0]; err_clr = clr[0];
    @(posedge clk);
    model_edge(rstn, sel, dig, clr);
    #1;
    check_model();
  endtask

  typedef struct {
    int rstn; int sel; int dig; int clr;
    int efv;  int eerr; int eval;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int tx_sel, tx_dig, sel, dig;
    model_reset();
    prev_fv = 0;

    // digit in each row belongs to the select of the previous row
    vecs.push_back('{0, 0, 0,  0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,  0, 0, 0, 0});
    vecs.push_back('{1, 0, 9,  0, 0, 0, 0});   // priming cycle, digit ignored
    vecs.push_back('{1, 1, 3,  0, 0, 0, 0});
    vecs.push_back('{1, 2, 5,  0, 0, 0, 0});
    vecs.push_back('{1, 0, 7,  0, 1, 0, 753});
    vecs.push_back('{1, 1, 3,  0, 0, 0, 753});
    vecs.push_back('{1, 2, 5,  0, 0, 0, 753});
    vecs.push_back('{1, 0, 7,  0, 1, 0, 753});
    vecs.push_back('{1, 2, 1,  0, 0, 0, 753});  // selects 0 then 2
    vecs.push_back('{1, 0, 2,  0, 0, 1, 753});
    vecs.push_back('{1, 1, 4,  0, 0, 1, 753});
    vecs.push_back('{1, 2, 0,  0, 0, 1, 753});
    vecs.push_back('{1, 0, 0,  0, 1, 1, 4});    // digits 4,0,0
    vecs.push_back('{1, 1, 9,  1, 0, 0, 4});
    vecs.push_back('{1, 2, 12, 0, 0, 1, 4});    // 0xC on tens slot
    vecs.push_back('{1, 3, 0,  0, 0, 1, 4});
    vecs.push_back('{1, 0, 0,  1, 0, 1, 4});    // clear meets sel_d = 3
    vecs.push_back('{1, 1, 2,  1, 0, 0, 4});    // clear alone
    vecs.push_back('{1, 2, 6,  0, 0, 0, 4});
    vecs.push_back('{0, 0, 8,  0, 0, 0, 0});    // reset between tens and hundreds
    vecs.push_back('{1, 0, 0,  0, 0, 0, 0});
    vecs.push_back('{1, 1, 1,  0, 0, 0, 0});
    vecs.push_back('{1, 2, 2,  0, 0, 0, 0});
    vecs.push_back('{1, 0, 3,  0, 1, 0, 321});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rstn, vecs[i].sel, vecs[i].dig, vecs[i].clr);
      check($sformatf("vec%0d_fv", i), frame_valid, vecs[i].efv);
      check($sformatf("vec%0d_err", i), seq_err, vecs[i].eerr);
      check($sformatf("vec%0d_val", i), value_bin, vecs[i].eval);
    end

    // Hand sequence: digits 0,0,4 give ones=4, tens=0, hundreds=0
    step(1, 1, 4, 1);
    step(1, 2, 0, 0);
    step(1, 0, 0, 0);
    check("lz_seg_ones", seg_ones, 7'b1100110);
`ifdef T09_LZ_BLANK_EN
    check("lz_seg_tens", seg_tens, 0);
    check("lz_seg_hundreds", seg_hundreds, 0);
`else
    check("lz_seg_tens", seg_tens, 7'b0111111);
    check("lz_seg_hundreds", seg_hundreds, 7'b0111111);
`endif

    // Randomized traffic: mostly well-formed frames with injected faults
    tx_sel = 1;
    tx_dig = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99) < 90) sel = tx_sel;
      else sel = $urandom_range(3);
      tx_sel = (sel + 1) % 3;
      dig = ($urandom_range(99) < 93) ? $urandom_range(9) : $urandom_range(15);
      step(($urandom_range(199) == 0) ? 0 : 1, sel, dig,
           ($urandom_range(99) < 5) ? 1 : 0);
      tx_dig = dig;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
